// File: rtl/cfg_sched_pkg.sv
// Shared types and constants for the config scheduler and its word FIFO.
package cfg_sched_pkg;

  localparam int CFG_BITS_DEF = 24;
  localparam int WD_W         = 16;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_END} state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// First-word-fall-through FIFO holding host config words.
module cfg_word_fifo
  import cfg_sched_pkg::*;
#(
  parameter int W     = CFG_BITS_DEF,
  parameter int DEPTH = 4
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr,
  input  logic [W-1:0]            i_wdata,
  input  logic                    i_rd,
  output logic [W-1:0]            o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [lvl_w(DEPTH)-1:0] o_level
);

  localparam int LW = lvl_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_lvl;
  logic          w_push, w_pop;

  assign o_full  = (r_lvl == LW'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign o_level = r_lvl;
  assign o_rdata = r_mem[r_rp];

  // A write while full is dropped even if a pop happens in the same cycle.
  assign w_push = i_wr && !o_full;
  assign w_pop  = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/config_scheduler.sv
// Launches buffered host config words (or a periodic refresh of the last good word)
// in the inter-frame window. Refresh exists only when CFG_SCHED_REFRESH_EN is defined.
module config_scheduler
  import cfg_sched_pkg::*;
#(
  parameter int C_NO_CFG_BITS     = CFG_BITS_DEF,
  parameter int FIFO_DEPTH        = 4,
  parameter int REFRESH_FRAMES    = 16,
  parameter int TX_TIMEOUT_CYCLES = 65535
)(
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         WR_EN,
  input  logic [C_NO_CFG_BITS-1:0]     WR_DATA,
  output logic                         WR_FULL,
  output logic [lvl_w(FIFO_DEPTH)-1:0] FIFO_LEVEL,
  input  logic                         FRAME_END,
  output logic                         CFG_START,
  output logic [C_NO_CFG_BITS-1:0]     CFG_INPUT,
  input  logic                         CFG_TX_END,
  output logic                         BUSY,
  output logic [C_NO_CFG_BITS-1:0]     LAST_CFG,
  output logic                         ERR_TIMEOUT,
  input  logic                         ERR_CLR
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (REFRESH_FRAMES < 1 || REFRESH_FRAMES > 255) begin : g_bad_refresh
    $error("REFRESH_FRAMES must be in 1..255");
  end
  if (TX_TIMEOUT_CYCLES < 2 || TX_TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TX_TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t                   r_state;
  logic                     r_start, r_busy, r_err, r_last_valid;
  logic [C_NO_CFG_BITS-1:0] r_cur, r_last;
  logic [WD_W-1:0]          r_wd;
  logic [C_NO_CFG_BITS-1:0] w_head;
  logic                     w_empty, w_pop, w_cnt_hit, w_refresh, w_tmo;

  cfg_word_fifo #(.W(C_NO_CFG_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_wr    (WR_EN),
    .i_wdata (WR_DATA),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (WR_FULL),
    .o_empty (w_empty),
    .o_level (FIFO_LEVEL)
  );

  assign w_pop = (r_state == IDLE) && FRAME_END && !w_empty;
  // r_wd counts cycles since the CFG_START cycle; firing one short of the limit
  // makes the flag visible exactly TX_TIMEOUT_CYCLES after START.
  assign w_tmo = (r_state == WAIT_END) && !CFG_TX_END &&
                 (r_wd == WD_W'(TX_TIMEOUT_CYCLES - 1));

`ifdef CFG_SCHED_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_FRAMES + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET)
      r_cnt <= '0;
    else if (r_state == WAIT_END && CFG_TX_END)
      r_cnt <= '0;
    else if (FRAME_END && r_cnt != CNT_W'(REFRESH_FRAMES))
      r_cnt <= r_cnt + 1'b1;
  end

  assign w_cnt_hit = (r_cnt == CNT_W'(REFRESH_FRAMES));
`else
  assign w_cnt_hit = 1'b0;
`endif

  assign w_refresh = r_last_valid && w_cnt_hit;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_last_valid <= 1'b0;
      r_cur        <= '0;
      r_last       <= '0;
      r_wd         <= '0;
    end else begin
      r_start <= 1'b0;
      if (ERR_CLR) r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (FRAME_END && (!w_empty || w_refresh)) begin
            r_cur   <= !w_empty ? w_head : r_last;
            r_state <= LAUNCH;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_wd    <= '0;
          end
        end
        LAUNCH: begin
          r_wd    <= r_wd + 1'b1;
          r_state <= WAIT_END;
        end
        WAIT_END: begin
          r_wd <= r_wd + 1'b1;
          if (CFG_TX_END) begin
            r_last       <= r_cur;
            r_last_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else if (w_tmo) begin
            r_err   <= 1'b1;   // overrides a same-cycle ERR_CLR
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign CFG_START   = r_start;
  assign CFG_INPUT   = r_cur;
  assign BUSY        = r_busy;
  assign LAST_CFG    = r_last;
  assign ERR_TIMEOUT = r_err;

endmodule

// File: tb/tb_config_scheduler.sv
// Directed scenarios plus randomized traffic against a transaction-level model of config_scheduler.
module tb_config_scheduler;

  localparam int W     = 24;
  localparam int DEPTH = 4;
  localparam int RF    = 3;
  localparam int TMO   = 50;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1, WR_EN = 1'b0, FRAME_END = 1'b0, CFG_TX_END = 1'b0, ERR_CLR = 1'b0;
  logic [W-1:0]  WR_DATA = '0;
  logic [W-1:0]  CFG_INPUT, LAST_CFG;
  logic          WR_FULL, CFG_START, BUSY, ERR_TIMEOUT;
  logic [2:0]    FIFO_LEVEL;

  always #5 CLOCK = ~CLOCK;

  config_scheduler #(
    .C_NO_CFG_BITS(W), .FIFO_DEPTH(DEPTH), .REFRESH_FRAMES(RF), .TX_TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL),
    .FIFO_LEVEL(FIFO_LEVEL), .FRAME_END(FRAME_END), .CFG_START(CFG_START),
    .CFG_INPUT(CFG_INPUT), .CFG_TX_END(CFG_TX_END), .BUSY(BUSY), .LAST_CFG(LAST_CFG),
    .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_CLR(ERR_CLR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a word queue plus the transfer status, advanced once per clock.
  logic [W-1:0] q[$];
  int           cnt, m_age;
  logic [W-1:0] m_cur, m_last;
  bit           m_lv, m_busy, m_start, m_err;

  task automatic model_step(input bit rst, input bit wr, input logic [W-1:0] wd,
                            input bit fe, input bit txe, input bit clr);
    bit full0, waiting, done, tmo, launch;
    if (rst) begin
      q.delete();
      cnt = 0; m_age = 0; m_cur = '0; m_last = '0;
      m_lv = 0; m_busy = 0; m_start = 0; m_err = 0;
      return;
    end
    full0   = (q.size() == DEPTH);
    waiting = m_busy && !m_start;
    done    = waiting && txe;
    tmo     = waiting && !txe && (m_age + 1 == TMO);
    launch  = 0;
    if (!m_busy && fe) begin
      if (q.size() > 0) begin
        m_cur = q.pop_front();
        launch = 1;
      end
`ifdef CFG_SCHED_REFRESH_EN
      else if (m_lv && cnt == RF) begin
        m_cur = m_last;
        launch = 1;
      end
`endif
    end
    if (wr && !full0) q.push_back(wd);
    if (done) cnt = 0;
    else if (fe && cnt < RF) cnt++;
    if (done) begin m_last = m_cur; m_lv = 1; m_busy = 0; end
    if (tmo) begin m_err = 1; m_busy = 0; end
    else if (clr) m_err = 0;
    m_start = launch;
    if (launch) begin m_busy = 1; m_age = 0; end
    else if (m_busy) m_age++;
  endtask

  task automatic check_all();
    chk("WR_FULL",     WR_FULL,     q.size() == DEPTH);
    chk("FIFO_LEVEL",  FIFO_LEVEL,  q.size());
    chk("CFG_START",   CFG_START,   m_start);
    chk("CFG_INPUT",   CFG_INPUT,   m_cur);
    chk("BUSY",        BUSY,        m_busy);
    chk("LAST_CFG",    LAST_CFG,    m_last);
    chk("ERR_TIMEOUT", ERR_TIMEOUT, m_err);
  endtask

  task automatic cyc(input bit rst, input bit wr, input logic [W-1:0] wd,
                     input bit fe, input bit txe, input bit clr);
    RESET = rst; WR_EN = wr; WR_DATA = wd; FRAME_END = fe; CFG_TX_END = txe; ERR_CLR = clr;
    @(posedge CLOCK);
    model_step(rst, wr, wd, fe, txe, clr);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "simulation time limit");
  end

  logic [W-1:0] wds [5];

  initial begin
    wds = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};

    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_last", LAST_CFG, 0);

    // Single word: START one cycle after FRAME_END, BUSY drops the cycle after TX_END
    cyc(0, 1, 24'hAEC9EC, 0, 0, 0);
    idle(5);
    cyc(0, 0, '0, 1, 0, 0);
    chk("t1_start", CFG_START, 1);
    chk("t1_input", CFG_INPUT, 24'hAEC9EC);
    idle(20);
    chk("t1_busy_hold", BUSY, 1);
    cyc(0, 0, '0, 0, 1, 0);
    chk("t1_busy_fall", BUSY, 0);
    chk("t1_last", LAST_CFG, 24'hAEC9EC);

    // Overfill: fifth word dropped, four sent in order
    for (int i = 0; i < 5; i++) cyc(0, 1, wds[i], 0, 0, 0);
    chk("t2_full", WR_FULL, 1);
    chk("t2_level", FIFO_LEVEL, 4);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      cyc(0, 0, '0, 1, 0, 0);
      chk("t2_start", CFG_START, 1);
      chk("t2_order", CFG_INPUT, wds[i]);
      idle(3);
      cyc(0, 0, '0, 0, 1, 0);
    end
    chk("t2_level_end", FIFO_LEVEL, 0);
    chk("t2_last", LAST_CFG, wds[3]);

    // Refresh: three frames arm it, the fourth re-sends the last word
    for (int k = 0; k < 3; k++) begin
      idle(2);
      cyc(0, 0, '0, 1, 0, 0);
      chk("t3_no_start", CFG_START, 0);
    end
    idle(2);
    cyc(0, 0, '0, 1, 0, 0);
`ifdef CFG_SCHED_REFRESH_EN
    chk("t3_refresh_start", CFG_START, 1);
    chk("t3_refresh_word", CFG_INPUT, wds[3]);
    idle(2);
    cyc(0, 0, '0, 0, 1, 0);
`else
    chk("t3_no_refresh", CFG_START, 0);
`endif

    // Host word beats a pending refresh; refresh follows RF frames later
    for (int k = 0; k < 3; k++) begin
      idle(1);
      cyc(0, 0, '0, 1, 0, 0);
    end
    cyc(0, 1, 24'h123456, 0, 0, 0);
    idle(1);
    cyc(0, 0, '0, 1, 0, 0);
    chk("t4_host_start", CFG_START, 1);
    chk("t4_host_word", CFG_INPUT, 24'h123456);
    idle(2);
    cyc(0, 0, '0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      cyc(0, 0, '0, 1, 0, 0);
      chk("t4_no_start", CFG_START, 0);
    end
    idle(1);
    cyc(0, 0, '0, 1, 0, 0);
`ifdef CFG_SCHED_REFRESH_EN
    chk("t4_refresh_word", CFG_INPUT, 24'h123456);
    chk("t4_refresh_start", CFG_START, 1);
    idle(2);
    cyc(0, 0, '0, 0, 1, 0);
`else
    chk("t4_no_refresh", CFG_START, 0);
`endif

    // Watchdog: flag at START+TMO, word discarded, LAST_CFG kept
    cyc(0, 1, 24'h0F0F0F, 0, 0, 0);
    idle(1);
    cyc(0, 0, '0, 1, 0, 0);
    idle(TMO - 1);
    chk("t5_err_early", ERR_TIMEOUT, 0);
    chk("t5_busy_early", BUSY, 1);
    idle(1);
    chk("t5_err_set", ERR_TIMEOUT, 1);
    chk("t5_busy_clr", BUSY, 0);
    chk("t5_last_kept", LAST_CFG, 24'h123456);
    chk("t5_level", FIFO_LEVEL, 0);
    cyc(0, 0, '0, 0, 0, 1);
    chk("t5_err_clr", ERR_TIMEOUT, 0);

    // FRAME_END during a transfer, then reset mid-transfer
    cyc(0, 1, 24'h55AA55, 0, 0, 0);
    cyc(0, 0, '0, 1, 0, 0);
    idle(3);
    cyc(0, 0, '0, 1, 0, 0);
    chk("t6_no_extra", CFG_START, 0);
    idle(2);
    cyc(1, 0, '0, 0, 0, 0);
    chk("t6_start0", CFG_START, 0);
    chk("t6_input0", CFG_INPUT, 0);
    chk("t6_busy0", BUSY, 0);
    chk("t6_last0", LAST_CFG, 0);
    chk("t6_err0", ERR_TIMEOUT, 0);
    chk("t6_level0", FIFO_LEVEL, 0);
    chk("t6_full0", WR_FULL, 0);
    idle(4);
    cyc(0, 0, '0, 1, 0, 0);
    chk("t6_no_launch", CFG_START, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 599) == 0,
          $urandom_range(0, 3) == 0,
          W'($urandom),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 14) == 0,
          $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
